// File: rtl/vc_rr_arbiter_if.sv
// Request/grant bundle between the NoC VC buffers (master) and vc_rr_arbiter (slave).
interface vc_rr_arbiter_if #(
    parameter int NUM_VC = 8
);
    localparam int IDX_W = $clog2(NUM_VC);

    logic [NUM_VC-1:0] zastavice_in;
    logic              release_in;
    logic              ready_in;
    logic [NUM_VC-1:0] zastavice_out;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              timeout_pulse;

    modport master (
        output zastavice_in, release_in, ready_in,
        input  zastavice_out, grant_valid, grant_idx, timeout_pulse
    );

    modport slave (
        input  zastavice_in, release_in, ready_in,
        output zastavice_out, grant_valid, grant_idx, timeout_pulse
    );
endinterface

// File: rtl/vc_rr_arbiter.sv
// Round-robin VC arbiter holding a registered one-hot grant for a whole packet.
// Optional forced revoke after MAX_HOLD grant cycles when VC_ARB_TIMEOUT_EN is defined.
module vc_rr_arbiter #(
    parameter int NUM_VC   = 8,
    parameter int MAX_HOLD = 64
) (
    input logic            clk,
    input logic            rst_n,
    vc_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_VC);
    localparam logic [NUM_VC-1:0] ONE_HOT0 = {{(NUM_VC-1){1'b0}}, 1'b1};

    if ((NUM_VC < 2) || (NUM_VC > 32)) begin : g_bad_num_vc
        $error("vc_rr_arbiter: NUM_VC must be in 2..32");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("vc_rr_arbiter: MAX_HOLD must be >= 2");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t            state_r, state_nxt_s;
    logic [NUM_VC-1:0] grant_r, grant_nxt_s;
    logic [IDX_W-1:0]  idx_r, idx_nxt_s;
    logic [IDX_W-1:0]  ptr_r, ptr_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic              pulse_r, pulse_nxt_s;
    logic [IDX_W-1:0]  pick_s, idx_inc_s;
    logic              req_any_s, release_s, drop_s, expire_s, end_s;

    // First requesting VC at or after ptr, wrapping at NUM_VC (not 2**IDX_W).
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_VC-1:0] req,
                                                 input logic [IDX_W-1:0]  ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               c;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_VC; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_VC) begin
                c = c - NUM_VC;
            end else begin
                c = c;
            end
            if (!found && req[IDX_W'(c)]) begin
                sel   = IDX_W'(c);
                found = 1'b1;
            end else begin
                sel   = sel;
            end
        end
        return sel;
    endfunction

    assign req_any_s = |bus.zastavice_in;
    assign pick_s    = rr_pick(bus.zastavice_in, ptr_r);
    assign release_s = bus.release_in & bus.ready_in;
    assign drop_s    = ~bus.zastavice_in[idx_r];
    assign idx_inc_s = (idx_r == IDX_W'(NUM_VC - 1)) ? '0 : idx_r + IDX_W'(1);
    assign end_s     = release_s | drop_s | expire_s;

`ifdef VC_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt_r;

    assign expire_s = (state_r == GRANT) && (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));

    // Hold counter: zero throughout IDLE so every grant starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= '0;
        end else if (state_r == IDLE) begin
            hold_cnt_r <= '0;
        end else if (!expire_s) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: GRANT always returns through IDLE, forcing a one-cycle bubble.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = req_any_s ? GRANT : IDLE;
            GRANT:   state_nxt_s = end_s ? IDLE : GRANT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output/next-datapath values; the grant is frozen while in GRANT.
    always_comb begin
        grant_nxt_s = grant_r;
        idx_nxt_s   = idx_r;
        valid_nxt_s = valid_r;
        ptr_nxt_s   = ptr_r;
        pulse_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    grant_nxt_s = ONE_HOT0 << pick_s;
                    idx_nxt_s   = pick_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    grant_nxt_s = '0;
                    idx_nxt_s   = '0;
                    valid_nxt_s = 1'b0;
                end
            end
            GRANT: begin
                if (end_s) begin
                    grant_nxt_s = '0;
                    idx_nxt_s   = '0;
                    valid_nxt_s = 1'b0;
                    ptr_nxt_s   = idx_inc_s;
                    pulse_nxt_s = expire_s & ~release_s & ~drop_s;
                end else begin
                    pulse_nxt_s = 1'b0;
                end
            end
            default: begin
                grant_nxt_s = '0;
                idx_nxt_s   = '0;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r <= '0;
            idx_r   <= '0;
            valid_r <= 1'b0;
            ptr_r   <= '0;
            pulse_r <= 1'b0;
        end else begin
            grant_r <= grant_nxt_s;
            idx_r   <= idx_nxt_s;
            valid_r <= valid_nxt_s;
            ptr_r   <= ptr_nxt_s;
            pulse_r <= pulse_nxt_s;
        end
    end

    assign bus.zastavice_out = grant_r;
    assign bus.grant_idx     = idx_r;
    assign bus.grant_valid   = valid_r;
    assign bus.timeout_pulse = pulse_r;
endmodule
